piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per i_en tick on a single serial line, with a frame strobe and a done pulse. It is the transmit end for the team's serial-in shift_reg receiver. With both blocks sharing i_clk/i_en, the receiver holds the word after WIDTH ticks.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
i_en  input  1  bit-rate tick; each high cycle advances one serial bit.
i_valid  input  1  parallel word valid.
i_data  input  WIDTH  parallel word; sampled only on handshake.
o_ready  output  1  word can be accepted this cycle.
o_data_out  output  1  serial data bit.
o_frame  output  1  high while o_data_out carries a valid bit.
o_done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Registers: state {IDLE, SHIFT}, sreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], done_q.
- Reset (async, i_rst_n=0): state=IDLE, sreg=0, cnt=0, done_q=0. Outputs during and after reset: o_ready=1, o_data_out=0, o_frame=0, o_done=0.
- Handshake: a word is accepted on a rising edge where i_valid && o_ready. i_data is ignored otherwise. i_valid may drop without acceptance with no effect.
- o_ready is combinational: (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && i_en).
- IDLE: o_frame=0, o_data_out=0. On accept: sreg<=i_data, cnt<=0, state<=SHIFT. Acceptance does not need i_en. The first bit appears the cycle after accept.
- SHIFT: o_frame=1. o_data_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0]. Each bit is held until the edge on which i_en=1.
  - On i_en with cnt<WIDTH-1: shift sreg toward the output end (MSB_FIRST: left, zero fill at bit 0; else right, zero fill at MSB), cnt<=cnt+1.
  - On i_en with cnt==WIDTH-1 (last bit): done_q<=1.
    - If i_valid is also high: back-to-back load; sreg<=i_data, cnt<=0, stay in SHIFT. o_frame stays high with no gap.
    - Otherwise: state<=IDLE.
  - With i_en=0: all state holds; i_valid is ignored (o_ready=0).
- o_done = done_q. It goes high the cycle after the last bit's i_en edge and clears next cycle, so it is a single pulse per word, including in back-to-back operation.
- Latency with i_en tied high: accept at edge 0, bits on cycles 1..WIDTH, o_done on cycle WIDTH+1. Sustained throughput is one word per WIDTH cycles.
- Reset mid-frame: frame aborted immediately, no o_done, o_frame=0 asynchronously. The next word starts fresh from bit 0.
- cnt never exceeds WIDTH-1, so there is no wrap beyond the word.
- No X-propagation: o_data_out is defined (0) in IDLE.

Test Plan:
1. Reset, then WIDTH=8, MSB_FIRST=1, i_en=1, send 0xA5 -> o_data_out over cycles 1..8 = 1,0,1,0,0,1,0,1. o_frame high for exactly 8 cycles. o_done pulses on cycle 9. o_ready=0 on cycles 1..7 and high again in IDLE.
2. MSB_FIRST=0, send 0x01 with i_en high every 3rd cycle -> first bit 1, then 0s. Each bit held 3 cycles. o_frame spans 24 cycles. o_done is one cycle.
3. Back-to-back: i_valid held high with words 0xFF then 0x00, i_en=1 -> 16 contiguous o_frame cycles, serial 8 ones then 8 zeros. o_done pulses after cycle 8 and after cycle 16. o_ready high on the last-bit cycle.
4. i_valid asserted mid-frame with i_en=0 and cnt=3 -> not accepted, o_ready=0, and the current word completes unchanged.
5. Assert i_rst_n=0 after 4 bits of 0xC3 -> o_frame, o_data_out and o_done go 0 immediately. After release o_ready=1, and a new word 0x3C serialises correctly from bit 0.
6. Loopback to shift_reg (WIDTH=8, shared i_en): random words, i_en random at 50% -> after each o_done, the receiver's parallel contents equal the sent word.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake and shifts it
// out one bit per i_en tick, with a frame strobe and a one-cycle done pulse per word.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_data_out,
    output logic             o_frame,
    output logic             o_done
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              last_bit;
    logic [WIDTH-1:0]  sreg_shifted;

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // Move the next bit toward the output end, zero filling behind it.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // Ready in idle, or on the last-bit tick so a new word can follow with no gap.
    always_comb begin
        o_ready = (state_q == StIdle) || ((state_q == StShift) && last_bit && i_en);
    end

    // Next-state logic: load on handshake, shift on tick, pulse done after the last bit.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    sreg_d  = i_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (i_en) begin
                    if (!last_bit) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CntW'(1);
                    end else begin
                        done_d = 1'b1;
                        if (i_valid) begin
                            sreg_d = i_data;
                            cnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any frame in progress immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Serial outputs are forced low outside a frame so the line never carries stale data.
    always_comb begin
        o_frame    = (state_q == StShift);
        o_data_out = 1'b0;
        if (state_q == StShift) begin
            o_data_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end
        o_done = done_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance, a bit-level scoreboard
// per instance, and a behavioural serial-in receiver looped back from the MSB-first instance.
module tb_piso_serializer;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         en_m = 1'b0, val_m = 1'b0;
    logic [W-1:0] dat_m = '0;
    logic         rdy_m, do_m, fr_m, dn_m;
    logic         en_l = 1'b0, val_l = 1'b0;
    logic [W-1:0] dat_l = '0;
    logic         rdy_l, do_l, fr_l, dn_l;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_m (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en_m),
        .i_valid    (val_m),
        .i_data     (dat_m),
        .o_ready    (rdy_m),
        .o_data_out (do_m),
        .o_frame    (fr_m),
        .o_done     (dn_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_l (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en_l),
        .i_valid    (val_l),
        .i_data     (dat_l),
        .o_ready    (rdy_l),
        .o_data_out (do_l),
        .o_frame    (fr_l),
        .o_done     (dn_l)
    );

    // Serial-in receiver sharing the transmitter's tick.
    logic [W-1:0] rx = '0;
    always_ff @(posedge clk) begin
        if (en_m && fr_m) rx <= {rx[W-2:0], do_m};
    end

    // Scoreboards: each entry is {last_bit_of_word, bit} in transmission order.
    logic [1:0]   mq[$];
    logic [1:0]   lq[$];
    logic [W-1:0] wq[$];
    logic         pend_m_v = 1'b0, pend_l_v = 1'b0;
    logic [W-1:0] pend_m_w = '0, pend_l_w = '0;
    logic         xdone_m = 1'b0, xdone_l = 1'b0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, retire consumed bits, advance the clock,
    // load words the bench expects to have been accepted, then check the done pulses.
    task automatic cyc();
        logic pop;
        logic xb;
        #1;
        xb = 1'b0;
        if (mq.size() != 0) xb = mq[0][0];
        chk("m_frame", 32'(fr_m), 32'(mq.size() != 0));
        chk("m_data", 32'(do_m), 32'(xb));
        chk("m_ready", 32'(rdy_m), 32'(mq.size() == 0 || (mq.size() == 1 && en_m)));
        pop = en_m && (mq.size() != 0);
        xdone_m = 1'b0;
        if (pop) begin
            xdone_m = mq[0][1];
            void'(mq.pop_front());
        end
        xb = 1'b0;
        if (lq.size() != 0) xb = lq[0][0];
        chk("l_frame", 32'(fr_l), 32'(lq.size() != 0));
        chk("l_data", 32'(do_l), 32'(xb));
        chk("l_ready", 32'(rdy_l), 32'(lq.size() == 0 || (lq.size() == 1 && en_l)));
        pop = en_l && (lq.size() != 0);
        xdone_l = 1'b0;
        if (pop) begin
            xdone_l = lq[0][1];
            void'(lq.pop_front());
        end
        @(posedge clk);
        #1;
        if (pend_m_v) begin
            for (int i = W - 1; i >= 0; i--) mq.push_back({(i == 0), pend_m_w[i]});
            wq.push_back(pend_m_w);
            pend_m_v = 1'b0;
        end
        if (pend_l_v) begin
            for (int i = 0; i < W; i++) lq.push_back({(i == W - 1), pend_l_w[i]});
            pend_l_v = 1'b0;
        end
        chk("m_done", 32'(dn_m), 32'(xdone_m));
        chk("l_done", 32'(dn_l), 32'(xdone_l));
        if (xdone_m && wq.size() != 0) chk("loopback", 32'(rx), 32'(wq.pop_front()));
    endtask

    task automatic send_m(input logic [W-1:0] w);
        val_m    = 1'b1;
        dat_m    = w;
        pend_m_v = 1'b1;
        pend_m_w = w;
        cyc();
        val_m = 1'b0;
    endtask

    task automatic send_l(input logic [W-1:0] w);
        val_l    = 1'b1;
        dat_l    = w;
        pend_l_v = 1'b1;
        pend_l_w = w;
        cyc();
        val_l = 1'b0;
    endtask

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_frame", 32'(fr_m), 32'd0);
        chk("rst_m_data", 32'(do_m), 32'd0);
        chk("rst_m_done", 32'(dn_m), 32'd0);
        chk("rst_m_ready", 32'(rdy_m), 32'd1);
        chk("rst_l_frame", 32'(fr_l), 32'd0);
        chk("rst_l_ready", 32'(rdy_l), 32'd1);
        mq.delete();
        lq.delete();
        wq.delete();
        pend_m_v = 1'b0;
        pend_l_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        #3;
        do_reset();

        // 1: 0xA5 MSB first with the tick tied high.
        en_m = 1'b1;
        send_m(8'hA5);
        repeat (10) cyc();

        // 2: 0x01 LSB first, one tick every third cycle.
        en_l = 1'b0;
        send_l(8'h01);
        for (int i = 0; i < 30; i++) begin
            en_l = (i % 3 == 2);
            cyc();
        end
        en_l = 1'b0;

        // 3: back-to-back 0xFF then 0x00 with valid held high.
        en_m  = 1'b1;
        val_m = 1'b1;
        dat_m = 8'hFF;
        pend_m_v = 1'b1;
        pend_m_w = 8'hFF;
        cyc();
        dat_m = 8'h00;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                pend_m_v = 1'b1;
                pend_m_w = 8'h00;
            end
            cyc();
        end
        val_m = 1'b0;
        repeat (10) cyc();

        // 4: valid offered mid-frame while the tick is low must be ignored.
        en_m = 1'b1;
        send_m(8'h96);
        repeat (3) cyc();
        en_m  = 1'b0;
        val_m = 1'b1;
        dat_m = 8'hFF;
        repeat (3) cyc();
        val_m = 1'b0;
        en_m  = 1'b1;
        repeat (7) cyc();

        // 5: reset after four bits of 0xC3, then 0x3C from a clean start.
        send_m(8'hC3);
        repeat (4) cyc();
        do_reset();
        send_m(8'h3C);
        repeat (10) cyc();

        // 6: random words, tick at roughly 50%, checked against the looped-back receiver.
        for (int k = 0; k < 8; k++) begin
            en_m = 1'($urandom_range(0, 1));
            send_m(W'($urandom));
            budget = 0;
            while (mq.size() != 0 && budget < 300) begin
                en_m = 1'($urandom_range(0, 1));
                cyc();
                budget++;
            end
            if (budget >= 300) chk("random_timeout", 32'(mq.size()), 32'd0);
            en_m = 1'b0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
